// File: rtl/serial_add_ctrl_if.sv
// Bundles the request, full-adder loop and result signals of serial_add_ctrl.
// Latency: none; this file only carries wires between the requester, the adder and the controller.
// Backpressure: a start is taken only while busy is low. Optional ovf exists when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    // Requester side, which also hosts the external one-bit full adder.
    modport master (
`ifdef SERIAL_ADD_OVF_EN
        input  ovf,
`endif
        output start, op_a, op_b, cin, fa_sum, fa_cout,
        input  fa_a, fa_b, fa_cin, busy, done, result, cout
    );

    // Controller side.
    modport slave (
`ifdef SERIAL_ADD_OVF_EN
        output ovf,
`endif
        input  start, op_a, op_b, cin, fa_sum, fa_cout,
        output fa_a, fa_b, fa_cin, busy, done, result, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: it feeds one operand bit pair per cycle through an external full adder.
// Latency: start is accepted at edge 0, busy is high for cycles 1..WIDTH, and done pulses in cycle WIDTH+1.
// Backpressure: start is ignored while busy. Defining SERIAL_ADD_OVF_EN adds the signed overflow output ovf.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_bit;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // The MSB is being processed when the counter reaches WIDTH-1. The counter stops at WIDTH, so it never wraps.
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Register all state. Reset clears everything and can abort a RUN with no done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Next-state and datapath: load on an accepted start, then shift one bit per RUN cycle.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d                = a_q >> 1;
                b_d                = b_q >> 1;
                result_d           = result_q >> 1;
                result_d[WIDTH-1]  = bus.fa_sum;
                carry_d            = bus.fa_cout;
                cnt_d              = cnt_q + CW'(1);
                if (last_bit) begin
                    state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
                    // On the MSB step, carry_q is the carry into the MSB and fa_cout is the carry out of it.
                    ovf_d   = carry_q ^ bus.fa_cout;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The adder inputs come only from registers and are held at zero outside RUN.
    assign bus.fa_a   = (state_q == RUN) & a_q[0];
    assign bus.fa_b   = (state_q == RUN) & b_q[0];
    assign bus.fa_cin = (state_q == RUN) & carry_q;

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    // After the last RUN edge the carry register holds the final carry-out. It stays put until the next start.
    assign bus.cout   = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl, using one WIDTH=8 instance and one WIDTH=1 instance.
// Each instance loops through a behavioural one-bit full adder.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_ctrl_if #(.WIDTH(W)) bus8();
    serial_add_ctrl_if #(.WIDTH(1)) bus1();

    serial_add_ctrl #(.WIDTH(W)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    assign bus8.fa_sum  = bus8.fa_a ^ bus8.fa_b ^ bus8.fa_cin;
    assign bus8.fa_cout = (bus8.fa_a & bus8.fa_b) | (bus8.fa_a & bus8.fa_cin) | (bus8.fa_b & bus8.fa_cin);
    assign bus1.fa_sum  = bus1.fa_a ^ bus1.fa_b ^ bus1.fa_cin;
    assign bus1.fa_cout = (bus1.fa_a & bus1.fa_b) | (bus1.fa_a & bus1.fa_cin) | (bus1.fa_b & bus1.fa_cin);

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           due;
    } exp8_t;

    typedef struct {
        logic res;
        logic co;
        int   due;
    } exp1_t;

    exp8_t q8[$];
    exp1_t q1[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: add the operands as unsigned integers for sum/carry, and as signed integers for overflow.
    function automatic exp8_t model8(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp8_t e;
        int unsigned s;
        int ss;
        s  = int'(a) + int'(b) + int'(c);
        ss = int'($signed(a)) + int'($signed(b)) + int'(c);
        e.res = W'(s % (1 << W));
        e.co  = ((s >> W) != 0);
        e.ov  = (ss > 127) || (ss < -128);
        e.due = 0;
        return e;
    endfunction

    // Must be called 1 time unit after a rising edge.
    task automatic issue8(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int n;
        exp8_t e;
        n = 0;
        while (bus8.busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus8.busy) chk("wait_idle8", 64'd1, 64'd0);
        bus8.start = 1'b1;
        bus8.op_a  = a;
        bus8.op_b  = b;
        bus8.cin   = c;
        @(posedge clk); #1;
        e = model8(a, b, c);
        e.due = cyc + W;
        q8.push_back(e);
        bus8.start = 1'b0;
        bus8.op_a  = W'($urandom);
        bus8.op_b  = W'($urandom);
        bus8.cin   = 1'($urandom);
        chk("busy_after_accept8", 64'(bus8.busy), 64'd1);
    endtask

    task automatic issue1(input logic a, input logic b, input logic c);
        int n;
        int s;
        exp1_t e;
        n = 0;
        while (bus1.busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus1.busy) chk("wait_idle1", 64'd1, 64'd0);
        bus1.start = 1'b1;
        bus1.op_a  = a;
        bus1.op_b  = b;
        bus1.cin   = c;
        @(posedge clk); #1;
        s = int'(a) + int'(b) + int'(c);
        e.res = (s % 2) != 0;
        e.co  = (s / 2) != 0;
        e.due = cyc + 1;
        q1.push_back(e);
        bus1.start = 1'b0;
    endtask

    // Monitor for the WIDTH=8 instance: compare each done against the scoreboard, and check the adder lines are quiet when not busy.
    always @(negedge clk) begin
        exp8_t e;
        if (!reset) begin
            if (bus8.done) begin
                if (q8.size() == 0) begin
                    chk("unexpected_done8", 64'd1, 64'd0);
                end else begin
                    e = q8.pop_front();
                    chk("done_cycle8", 64'(cyc), 64'(e.due));
                    chk("result8", 64'(bus8.result), 64'(e.res));
                    chk("cout8", 64'(bus8.cout), 64'(e.co));
`ifdef SERIAL_ADD_OVF_EN
                    chk("ovf8", 64'(bus8.ovf), 64'(e.ov));
`endif
                end
            end
            if (!bus8.busy)
                chk("fa_idle8", 64'({bus8.fa_a, bus8.fa_b, bus8.fa_cin}), 64'd0);
        end
    end

    // Monitor for the WIDTH=1 instance.
    always @(negedge clk) begin
        exp1_t e;
        if (!reset && bus1.done) begin
            if (q1.size() == 0) begin
                chk("unexpected_done1", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                chk("done_cycle1", 64'(cyc), 64'(e.due));
                chk("sum1", 64'({bus1.cout, bus1.result}), 64'({e.co, e.res}));
            end
        end
    end

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q8.size() != 0 || q1.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_q8", 64'(q8.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);
    endtask

    initial begin
        #200000;
        bad++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        reset = 1'b1;
        bus8.start = 1'b0; bus8.op_a = '0; bus8.op_b = '0; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus8.busy), 64'd0);
        chk("rst_done", 64'(bus8.done), 64'd0);
        chk("rst_result", 64'(bus8.result), 64'd0);
        chk("rst_cout", 64'(bus8.cout), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        issue8(8'h05, 8'h03, 1'b0);
        issue8(8'hFF, 8'h01, 1'b0);
        issue8(8'hFF, 8'hFF, 1'b1);
        issue8(8'h7F, 8'h01, 1'b0);
        issue8(8'h80, 8'hFF, 1'b0);
        drain(40);

        // A start pulsed in RUN cycle 4 must be ignored.
        issue8(8'h21, 8'h42, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        chk("busy_mid_run", 64'(bus8.busy), 64'd1);
        bus8.start = 1'b1; bus8.op_a = 8'hAA; bus8.op_b = 8'h55; bus8.cin = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        drain(40);

        // Reset asserted in RUN cycle 5 aborts the operation without a done pulse.
        issue8(8'h12, 8'h34, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        void'(q8.pop_back());
        chk("abort_busy", 64'(bus8.busy), 64'd0);
        chk("abort_done", 64'(bus8.done), 64'd0);
        chk("abort_result", 64'(bus8.result), 64'd0);
        chk("abort_cout", 64'(bus8.cout), 64'd0);
        chk("abort_fa", 64'({bus8.fa_a, bus8.fa_b, bus8.fa_cin}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        issue8(8'h10, 8'h20, 1'b0);
        drain(40);

        // Random back-to-back operations with occasional idle gaps.
        for (int i = 0; i < 40; i++) begin
            issue8(W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat (W + 1 + $urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end
        drain(60);

        // Exhaustive WIDTH=1 sweep
        for (int v = 0; v < 8; v++) begin
            issue1(v[2], v[1], v[0]);
        end
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter SHALL be: WIDTH, default 8, operand/result width in bits (legal range 1..32).
REQ-003 Port SHALL be: clk  in  1  rising-edge clock.
REQ-004 Port SHALL be: reset  in  1  asynchronous active-high reset.
REQ-005 Port SHALL be: start  in  1  request a new addition; sampled only when busy=0.
REQ-006 Port SHALL be: op_a  in  WIDTH  first operand, captured on accepted start.
REQ-007 Port SHALL be: op_b  in  WIDTH  second operand, captured on accepted start.
REQ-008 Port SHALL be: cin  in  1  initial carry-in, captured on accepted start.
REQ-009 Port SHALL be: fa_a  out  1  bit A driven to the external one-bit full adder.
REQ-010 Port SHALL be: fa_b  out  1  bit B driven to the external one-bit full adder.
REQ-011 Port SHALL be: fa_cin  out  1  carry-in driven to the external one-bit full adder.
REQ-012 Port SHALL be: fa_sum  in  1  sum bit returned by the full adder (combinational).
REQ-013 Port SHALL be: fa_cout  in  1  carry-out returned by the full adder (combinational).
REQ-014 Port SHALL be: busy  out  1  high while an addition is in progress.
REQ-015 Port SHALL be: done  out  1  one-cycle pulse when result/cout become valid.
REQ-016 Port SHALL be: result  out  WIDTH  sum, held stable from done until next accepted start.
REQ-017 Port SHALL be: cout  out  1  final carry-out, same validity as result.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-019 Start SHALL be accepted in IDLE or DONE: latch op_a/op_b into shift registers, cin into carry register, clear bit counter, go RUN.
REQ-020 Start during RUN SHALL be ignored; no operand, carry, or counter change.
REQ-021 In RUN, fa_a/fa_b SHALL be LSB of operand shift registers, fa_cin the carry register, all driven from registers (no start/op_* combinational path).
REQ-022 Each RUN edge SHALL shift fa_sum into result MSB, shift result and operands right by one, load fa_cout into carry register, increment counter.
REQ-023 After exactly WIDTH RUN cycles, FSM SHALL enter DONE; result[0] = first-processed bit (LSB), cout = final carry register.
REQ-024 Latency: start accepted at edge 0 -> busy=1 cycles 1..WIDTH -> done=1 in cycle WIDTH+1 only.
REQ-025 DONE SHALL last one cycle, then IDLE unless start accepted (back-to-back: DONE -> RUN, no idle gap).
REQ-026 In IDLE and DONE, fa_a, fa_b, fa_cin SHALL be 0.
REQ-027 Result SHALL equal (op_a + op_b + cin) mod 2^WIDTH, cout = bit WIDTH of that sum; WIDTH=1 SHALL work (single RUN cycle).
REQ-028 The counter SHALL be clog2(WIDTH+1) bits wide and SHALL not wrap within an operation.

Reset
REQ-029 Reset SHALL asynchronously force IDLE; busy=0, done=0, result=0, cout=0, carry/counter/shift registers=0, fa_*=0.
REQ-030 Reset mid-RUN SHALL abort without a done pulse; first start after reset deassertion SHALL be honored normally.

Configuration
REQ-031 Macro SERIAL_ADD_OVF_EN SHALL, when defined, add port ovf  out  1  signed two's-complement overflow, valid with result.
REQ-032 With SERIAL_ADD_OVF_EN, ovf SHALL equal carry into MSB XOR carry out of MSB, reset to 0, held with result.
REQ-033 Without SERIAL_ADD_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8, fa_* looped through a behavioural one-bit full adder)
REQ-034 op_a=0x05, op_b=0x03, cin=0, start at edge 0 -> done in cycle 9, result=0x08, cout=0.
REQ-035 op_a=0xFF, op_b=0x01, cin=0 -> result=0x00, cout=1; op_a=0xFF, op_b=0xFF, cin=1 -> result=0xFF, cout=1.
REQ-036 op_a=0x7F, op_b=0x01 with SERIAL_ADD_OVF_EN -> result=0x80, cout=0, ovf=1; 0x80+0xFF -> result=0x7F, cout=1, ovf=1.
REQ-037 Start pulsed with new operands in cycle 4 of RUN -> ignored; original sum reported; back-to-back start in DONE cycle -> second done exactly 9 cycles later.
REQ-038 Reset asserted in cycle 5 of RUN -> immediate IDLE, all outputs 0, no done; next 0x10+0x20 -> result=0x30.
REQ-039 Exhaustive sweep at WIDTH=1 of all op_a/op_b/cin -> {cout,result} = op_a+op_b+cin, done in cycle 2.
